// File: rtl/lzrw1_decompressor_top.sv
// LZRW1 decompressor: turns literal/copy items into a byte stream, one byte every two cycles,
// backed by a circular history buffer. Optional macro DECOMP_ERROR_CHECK_EN adds decode_error.
module lzrw1_decompressor_top #(
  parameter int HISTORY_SIZE = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        control_word_in,
  input  logic        data_in_valid,
  output logic [7:0]  decompressed_byte,
  output logic        out_valid,
  output logic        decompressor_busy
`ifdef DECOMP_ERROR_CHECK_EN
  ,
  output logic        decode_error
`endif
);

  localparam int AW = $clog2(HISTORY_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic [3:0]      remain_q, remain_d;
  logic [AW-1:0]   off_q, off_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_addr;
  logic            accept;

  logic [7:0]      hist [HISTORY_SIZE];

  assign accept = data_in_valid && (state_q == S_IDLE);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EMIT;
      S_EMIT:  state_d = S_GAP;
      S_GAP:   state_d = (remain_q != 4'd0) ? S_EMIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid         = (state_q == S_EMIT);
    decompressor_busy = (state_q != S_IDLE);
    decompressed_byte = byte_q;
  end

  // The read happens one cycle after the previous byte's write, so short offsets see fresh data.
  always_comb begin
    rd_addr  = wr_ptr_q - (accept ? data_in[AW-1:0] : off_q);
    byte_d   = byte_q;
    remain_d = remain_q;
    off_d    = off_q;
    wr_ptr_d = wr_ptr_q;
    if (accept) begin
      if (control_word_in) begin
        off_d    = data_in[AW-1:0];
        remain_d = data_in[15:12];
        byte_d   = hist[rd_addr];
      end else begin
        off_d    = '0;
        remain_d = 4'd0;
        byte_d   = data_in[7:0];
      end
    end else if (state_q == S_GAP && remain_q != 4'd0) begin
      byte_d   = hist[rd_addr];
      remain_d = remain_q - 4'd1;
    end
    if (state_q == S_EMIT) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_q   <= 8'd0;
      remain_q <= 4'd0;
      off_q    <= '0;
      wr_ptr_q <= '0;
    end else begin
      byte_q   <= byte_d;
      remain_q <= remain_d;
      off_q    <= off_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: history storage has no reset; its contents are undefined until written and reset never clears it.
  always_ff @(posedge clock) begin
    if (state_q == S_EMIT) begin
      hist[wr_ptr_q] <= byte_q;
    end
  end

`ifdef DECOMP_ERROR_CHECK_EN
  localparam int CW = AW + 1;

  logic [CW-1:0] emit_cnt_q, emit_cnt_d;
  logic          decode_error_q, decode_error_d;
  logic          off_bad;

  // Offset is checked on its full 12 bits, before reduction to the buffer size.
  always_comb begin
    off_bad = (data_in[11:0] == 12'd0)
           || ((32'(data_in[11:0]) >> AW) != 32'd0)
           || ({1'b0, data_in[11:0]} > 13'(emit_cnt_q));
    decode_error_d = decode_error_q;
    if (accept && control_word_in && off_bad) begin
      decode_error_d = 1'b1;
    end
    emit_cnt_d = emit_cnt_q;
    if (state_q == S_EMIT && emit_cnt_q != CW'(HISTORY_SIZE)) begin
      emit_cnt_d = emit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      emit_cnt_q     <= '0;
      decode_error_q <= 1'b0;
    end else begin
      emit_cnt_q     <= emit_cnt_d;
      decode_error_q <= decode_error_d;
    end
  end

  assign decode_error = decode_error_q;
`endif

endmodule

// File: tb/tb_lzrw1_decompressor_top.sv
// Directed bench for the LZRW1 decompressor (HISTORY_SIZE=256): literals, copies, overlapping
// runs, pointer wrap, busy hold-off, mid-item reset and, when enabled, the decode_error flag.
module tb_lzrw1_decompressor_top;

  logic        clock;
  logic        reset;
  logic [15:0] data_in;
  logic        control_word_in;
  logic        data_in_valid;
  logic [7:0]  decompressed_byte;
  logic        out_valid;
  logic        decompressor_busy;
`ifdef DECOMP_ERROR_CHECK_EN
  logic        decode_error;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  lzrw1_decompressor_top #(.HISTORY_SIZE(256)) dut (
    .clock             (clock),
    .reset             (reset),
    .data_in           (data_in),
    .control_word_in   (control_word_in),
    .data_in_valid     (data_in_valid),
    .decompressed_byte (decompressed_byte),
    .out_valid         (out_valid),
    .decompressor_busy (decompressor_busy)
`ifdef DECOMP_ERROR_CHECK_EN
    ,
    .decode_error      (decode_error)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after busy has dropped.
  task automatic run_item(input string tag, input logic [15:0] d, input logic c, input int len);
    data_in         = d;
    control_word_in = c;
    data_in_valid   = 1'b1;
    @(negedge clock);
    data_in_valid = 1'b0;
    for (int k = 0; k < len; k++) begin
      check($sformatf("%s emit_valid[%0d]", tag, k), {15'd0, out_valid}, 16'd1);
      check($sformatf("%s byte[%0d]", tag, k), {8'd0, decompressed_byte}, {8'd0, exp_q[k]});
      check($sformatf("%s busy_emit[%0d]", tag, k), {15'd0, decompressor_busy}, 16'd1);
      @(negedge clock);
      check($sformatf("%s gap_valid[%0d]", tag, k), {15'd0, out_valid}, 16'd0);
      check($sformatf("%s gap_hold[%0d]", tag, k), {8'd0, decompressed_byte}, {8'd0, exp_q[k]});
      check($sformatf("%s busy_gap[%0d]", tag, k), {15'd0, decompressor_busy}, 16'd1);
      @(negedge clock);
    end
    check($sformatf("%s busy_done", tag), {15'd0, decompressor_busy}, 16'd0);
    check($sformatf("%s valid_done", tag), {15'd0, out_valid}, 16'd0);
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    reset           = 1'b0;
    data_in         = 16'h0000;
    control_word_in = 1'b0;
    data_in_valid   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst byte", {8'd0, decompressed_byte}, 16'h0000);
    check("rst valid", {15'd0, out_valid}, 16'd0);
    check("rst busy", {15'd0, decompressor_busy}, 16'd0);
`ifdef DECOMP_ERROR_CHECK_EN
    check("rst decode_error", {15'd0, decode_error}, 16'd0);
`endif
    reset = 1'b1;
    @(negedge clock);

    // Single literal: hist[0]=0x41
    exp_q.push_back(8'h41);
    run_item("lit41", 16'h0041, 1'b0, 1);

    // 'a','b','c' at hist[1..3] (upper byte of a literal is ignored), then copy offset 3 length 3
    exp_q.push_back(8'h61); run_item("lit_a", 16'hFF61, 1'b0, 1);
    exp_q.push_back(8'h62); run_item("lit_b", 16'h0062, 1'b0, 1);
    exp_q.push_back(8'h63); run_item("lit_c", 16'h0063, 1'b0, 1);
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    run_item("copy2003", 16'h2003, 1'b1, 3);

    // 'x' then a 16-byte offset-1 run of it; wr_ptr ends at 24
    exp_q.push_back(8'h78); run_item("lit_x", 16'h0078, 1'b0, 1);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'h78);
    run_item("copyF001", 16'hF001, 1'b1, 16);

    // 300 literals wrap the pointer; 255 bytes back from the end is literal 45
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(i[7:0]);
      run_item("wrap_lit", {8'h00, i[7:0]}, 1'b0, 1);
    end
    exp_q.push_back(8'd45);
    run_item("copy00FF", 16'h00FF, 1'b1, 1);

    // data_in_valid held high across the whole item: only one item may be consumed
    data_in         = 16'h0055;
    control_word_in = 1'b0;
    data_in_valid   = 1'b1;
    @(negedge clock);
    check("hold byte", {8'd0, decompressed_byte}, 16'h0055);
    check("hold valid1", {15'd0, out_valid}, 16'd1);
    data_in = 16'h0066;
    @(negedge clock);
    check("hold busy2", {15'd0, decompressor_busy}, 16'd1);
    @(negedge clock);
    check("hold busy3", {15'd0, decompressor_busy}, 16'd0);
    check("hold valid3", {15'd0, out_valid}, 16'd0);
    data_in_valid = 1'b0;
    @(negedge clock);
    check("hold valid4", {15'd0, out_valid}, 16'd0);
    check("hold byte4", {8'd0, decompressed_byte}, 16'h0055);

    // Reset in the middle of a 16-byte run
    data_in         = 16'hF001;
    control_word_in = 1'b1;
    data_in_valid   = 1'b1;
    @(negedge clock);
    data_in_valid = 1'b0;
    check("midrst byte0", {8'd0, decompressed_byte}, 16'h0055);
    @(negedge clock);
    @(negedge clock);
    check("midrst busy_pre", {15'd0, decompressor_busy}, 16'd1);
    check("midrst valid_pre", {15'd0, out_valid}, 16'd1);
    reset = 1'b0;
    #1;
    check("midrst valid", {15'd0, out_valid}, 16'd0);
    check("midrst busy", {15'd0, decompressor_busy}, 16'd0);
    check("midrst byte", {8'd0, decompressed_byte}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    // Pointer is back at 0: literal lands in hist[0] and offset 1 reads it back
    exp_q.push_back(8'h42); run_item("post_rst_lit", 16'h0042, 1'b0, 1);
    exp_q.push_back(8'h42); run_item("post_rst_copy", 16'h0001, 1'b1, 1);
`ifdef DECOMP_ERROR_CHECK_EN
    check("no_err_yet", {15'd0, decode_error}, 16'd0);
`endif

    // Offset 0 as first item: reads hist[0], flags an error that is sticky until reset
    pulse_reset();
    exp_q.push_back(8'h42); run_item("copy0000", 16'h0000, 1'b1, 1);
`ifdef DECOMP_ERROR_CHECK_EN
    check("err_off0", {15'd0, decode_error}, 16'd1);
`endif
    exp_q.push_back(8'h07); run_item("lit07", 16'h0007, 1'b0, 1);
`ifdef DECOMP_ERROR_CHECK_EN
    check("err_sticky", {15'd0, decode_error}, 16'd1);
`endif
    pulse_reset();
`ifdef DECOMP_ERROR_CHECK_EN
    check("err_cleared", {15'd0, decode_error}, 16'd0);
`endif

    // Offset beyond bytes emitted: reads stale hist[255] (literal 231)
    exp_q.push_back(8'h11); run_item("lit11", 16'h0011, 1'b0, 1);
    exp_q.push_back(8'hE7); run_item("copy_far", 16'h0002, 1'b1, 1);
`ifdef DECOMP_ERROR_CHECK_EN
    check("err_far", {15'd0, decode_error}, 16'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
